// File: rtl/sd4_mac_pkg.sv
// Shared types and default widths for the SD4 MAC accumulation path.
// Fraction widths exclude the hidden one; exponents are two's complement.
package sd4_mac_pkg;

    localparam int FRAC_W = 11;
    localparam int EXP_W  = 6;
    localparam int SUM_W  = 20;

    // The most negative exponent is reserved to encode a zero operand.
    localparam logic [EXP_W-1:0] EXP_ZERO = {1'b1, {(EXP_W-1){1'b0}}};

    typedef struct packed {
        logic              sign;
        logic [FRAC_W-1:0] frac;
        logic [EXP_W-1:0]  exp;
    } fp_operand_t;

    typedef enum logic {
        FILL = 1'b0,
        EMIT = 1'b1
    } align_state_t;

endpackage

// File: rtl/fp_align_shift.sv
// Combinational alignment of one operand to the group exponent, with negation.
// Define FP_ALIGN_ROUND_EN for round-to-nearest-even of the shifted-out bits; default truncates.
module fp_align_shift #(
    parameter int FRAC_W = sd4_mac_pkg::FRAC_W,
    parameter int EXP_W  = sd4_mac_pkg::EXP_W,
    parameter int SUM_W  = sd4_mac_pkg::SUM_W
) (
    input  logic [FRAC_W:0]  mag,
    input  logic [EXP_W-1:0] shift,
    input  logic             sign,
    input  logic             zero,
    output logic [SUM_W-1:0] val
);

    localparam int MAG_W = FRAC_W + 1;
    localparam int RND_W = MAG_W + 1;

    // One spare bit so a round-up carry out of the top is kept.
    logic [RND_W-1:0] rounded;
    logic [SUM_W-1:0] aligned;

`ifdef FP_ALIGN_ROUND_EN
    localparam logic [EXP_W-1:0] MAX_SHIFT = EXP_W'(MAG_W);

    logic [2*MAG_W-1:0] wide;
    logic [MAG_W-1:0]   kept;
    logic               guard;
    logic               sticky;

    // NOTE: every signal written in an always_comb gets a value before any branch, so no latch is inferred.
    always_comb begin
        rounded = '0;
        wide    = {mag, {MAG_W{1'b0}}} >> shift;
        kept    = wide[2*MAG_W-1:MAG_W];
        guard   = wide[MAG_W-1];
        sticky  = |wide[MAG_W-2:0];
        if (shift <= MAX_SHIFT) begin
            rounded = {1'b0, kept} + RND_W'(guard & (sticky | kept[0]));
        end
    end
`else
    localparam logic [EXP_W-1:0] MAX_SHIFT = EXP_W'(FRAC_W);

    always_comb begin
        rounded = '0;
        if (shift <= MAX_SHIFT) begin
            rounded = {1'b0, mag >> shift};
        end
    end
`endif

    always_comb begin
        aligned = SUM_W'(rounded);
        if (zero) begin
            aligned = '0;
        end
        val = sign ? -aligned : aligned;
    end

endmodule

// File: rtl/fp_group_aligner.sv
// Collects GROUP_SIZE fp operands, finds the max exponent, then emits each as fixed point.
// Rounding of shifted-out bits is enabled by defining FP_ALIGN_ROUND_EN (see fp_align_shift).
module fp_group_aligner
    import sd4_mac_pkg::*;
#(
    parameter int GROUP_SIZE = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [FRAC_W-1:0] in_frac,
    input  logic [EXP_W-1:0]  in_exp,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SUM_W-1:0]  out_val,
    output logic [EXP_W-1:0]  out_exp_max,
    output logic              out_last
);

    localparam int              CNT_W    = $clog2(GROUP_SIZE);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(GROUP_SIZE - 1);

    align_state_t     state, state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] k;
    logic [EXP_W-1:0] run_max;
    logic [EXP_W-1:0] exp_max;
    logic [EXP_W-1:0] max_next;
    fp_operand_t      buffer [GROUP_SIZE];

    logic             accept;
    logic             last_accept;
    logic             out_fire;
    logic [CNT_W-1:0] sel_idx;
    logic [EXP_W-1:0] sel_max;
    fp_operand_t      sel_op;
    logic [SUM_W-1:0] sel_val;

    assign in_ready    = (state == FILL);
    assign accept      = in_valid && in_ready;
    assign last_accept = accept && (cnt == LAST_IDX);
    assign out_fire    = out_valid && out_ready;
    // The zero code is the most negative value, so a signed compare never lets it win.
    assign max_next    = ($signed(in_exp) > $signed(run_max)) ? in_exp : run_max;

    // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            FILL:    if (last_accept) state_next = EMIT;
            EMIT:    if (out_fire && out_last) state_next = FILL;
            default: state_next = FILL;
        endcase
    end

    // NOTE: the operand buffer has no reset; every entry is written before EMIT reads it.
    always_ff @(posedge clk) begin
        if (accept) begin
            buffer[cnt] <= '{sign: in_sign, frac: in_frac, exp: in_exp};
        end
    end

    // Element 0 is loaded as the last operand arrives; later elements load on each handshake.
    always_comb begin
        sel_idx = (state == FILL) ? '0 : k + 1'b1;
        sel_max = (state == FILL) ? max_next : exp_max;
        sel_op  = buffer[sel_idx];
    end

    fp_align_shift #(
        .FRAC_W (FRAC_W),
        .EXP_W  (EXP_W),
        .SUM_W  (SUM_W)
    ) u_shift (
        .mag   ({1'b1, sel_op.frac}),
        .shift (sel_max - sel_op.exp),
        .sign  (sel_op.sign),
        .zero  (sel_op.exp == EXP_ZERO),
        .val   (sel_val)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            k           <= '0;
            run_max     <= EXP_ZERO;
            exp_max     <= EXP_ZERO;
            out_valid   <= 1'b0;
            out_val     <= '0;
            out_exp_max <= '0;
            out_last    <= 1'b0;
        end else begin
            if (accept) begin
                cnt     <= cnt + 1'b1;
                run_max <= max_next;
            end
            if (last_accept) begin
                cnt         <= '0;
                k           <= '0;
                exp_max     <= max_next;
                out_valid   <= 1'b1;
                out_val     <= sel_val;
                out_exp_max <= max_next;
                out_last    <= 1'b0;
            end else if (out_fire) begin
                if (out_last) begin
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    cnt       <= '0;
                    k         <= '0;
                    run_max   <= EXP_ZERO;
                end else begin
                    k        <= k + 1'b1;
                    out_val  <= sel_val;
                    out_last <= ((k + 1'b1) == LAST_IDX);
                end
            end
        end
    end

endmodule

// File: tb/tb_fp_group_aligner.sv
// Scoreboard bench for fp_group_aligner: directed groups push expectations, a monitor pops and compares.
// Expected values follow FP_ALIGN_ROUND_EN when it is defined.
module tb_fp_group_aligner;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [10:0] in_frac;
    logic [5:0]  in_exp;
    logic        out_valid;
    logic        out_ready;
    logic [19:0] out_val;
    logic [5:0]  out_exp_max;
    logic        out_last;

    fp_group_aligner #(.GROUP_SIZE(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_sign     (in_sign),
        .in_frac     (in_frac),
        .in_exp      (in_exp),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_val     (out_val),
        .out_exp_max (out_exp_max),
        .out_last    (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [19:0] val;
        logic [5:0]  emax;
        logic        last;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_out = 0;

    logic        g_sign [4];
    logic [10:0] g_frac [4];
    logic [5:0]  g_exp  [4];
    logic [19:0] g_val  [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: pops one expectation per handshake and checks holding under backpressure.
    logic        hold_pend;
    logic [19:0] h_val;
    logic [5:0]  h_emax;
    logic        h_last;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_val", 32'(out_val), 32'(h_val));
                check("hold_exp_max", 32'(out_exp_max), 32'(h_emax));
                check("hold_last", 32'(out_last), 32'(h_last));
            end
            hold_pend = 1'b0;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 32'(out_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("out_val[%0d]", n_out), 32'(out_val), 32'(e.val));
                    check($sformatf("out_exp_max[%0d]", n_out), 32'(out_exp_max), 32'(e.emax));
                    check($sformatf("out_last[%0d]", n_out), 32'(out_last), 32'(e.last));
                    n_out++;
                end
            end else if (out_valid) begin
                hold_pend = 1'b1;
                h_val     = out_val;
                h_emax    = out_exp_max;
                h_last    = out_last;
            end
        end
    end

    task automatic set_op(input int i, input logic s, input logic [10:0] f,
                          input logic [5:0] e, input logic [19:0] v);
        g_sign[i] = s;
        g_frac[i] = f;
        g_exp[i]  = e;
        g_val[i]  = v;
    endtask

    task automatic send_op(input logic s, input logic [10:0] f, input logic [5:0] e);
        int n;
        in_sign  = s;
        in_frac  = f;
        in_exp   = e;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 50) check("in_ready_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic load_group(input logic [5:0] emax);
        for (int i = 0; i < 4; i++) begin
            send_op(g_sign[i], g_frac[i], g_exp[i]);
            if (i < 3) check($sformatf("early_valid[%0d]", i), 32'(out_valid), 32'd0);
        end
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back('{val: g_val[i], emax: emax, last: (i == 3)});
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        check("drain_left", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
        check("idle_in_ready", 32'(in_ready), 32'd1);
        check("idle_out_valid", 32'(out_valid), 32'd0);
    endtask

    task automatic setup_group1();
        set_op(0, 1'b0, 11'h000, 6'd3,  20'h00800);
        set_op(1, 1'b1, 11'h400, 6'd1,  20'hFFD00);
        set_op(2, 1'b0, 11'h000, 6'h20, 20'h00000);
        set_op(3, 1'b0, 11'h7FF, 6'd3,  20'h00FFF);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sign   = 1'b0;
        in_frac   = '0;
        in_exp    = '0;
        out_ready = 1'b1;
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_val", 32'(out_val), 32'd0);
        check("rst_out_exp_max", 32'(out_exp_max), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Mixed signs, a zero operand, max fraction.
        setup_group1();
        load_group(6'd3);
        wait_drain();

        // All-zero group.
        for (int i = 0; i < 4; i++) set_op(i, i[0], 11'h155, 6'h20, 20'h00000);
        load_group(6'h20);
        wait_drain();

        // Shift well beyond the fraction width.
        set_op(0, 1'b0, 11'h000, 6'd10, 20'h00800);
        set_op(1, 1'b0, 11'h123, 6'h3B, 20'h00000);
        set_op(2, 1'b1, 11'h000, 6'd10, 20'hFF800);
        set_op(3, 1'b0, 11'h7FE, 6'd9,  20'h007FF);
        load_group(6'd10);
        wait_drain();

        // Guard-bit handling at shift 1.
        set_op(0, 1'b0, 11'h000, 6'd1,  20'h00800);
        set_op(1, 1'b0, 11'h001, 6'd0,  20'h00400);
`ifdef FP_ALIGN_ROUND_EN
        set_op(2, 1'b0, 11'h003, 6'd0,  20'h00402);
`else
        set_op(2, 1'b0, 11'h003, 6'd0,  20'h00401);
`endif
        set_op(3, 1'b1, 11'h000, 6'h20, 20'h00000);
        load_group(6'd1);
        wait_drain();

        // Backpressure mid-EMIT with in_valid held high.
        set_op(0, 1'b0, 11'h000, 6'd0,  20'h00800);
        set_op(1, 1'b0, 11'h000, 6'h3F, 20'h00400);
        set_op(2, 1'b0, 11'h000, 6'h3E, 20'h00200);
        set_op(3, 1'b1, 11'h000, 6'h3D, 20'hFFF00);
        load_group(6'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_sign   = 1'b0;
        in_frac   = 11'h0AA;
        in_exp    = 6'd5;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("emit_in_ready[%0d]", i), 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        wait_drain();

        // Abort a partial group with reset, then run a fresh group.
        send_op(1'b0, 11'h7FF, 6'd20);
        send_op(1'b1, 11'h7FF, 6'd25);
        rst_n = 1'b0;
        #3;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        setup_group1();
        load_group(6'd3);
        wait_drain();

        check("total_outputs", 32'(n_out), 32'd24);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
